// File: rtl/core_pkg.sv
// Shared types for the MEM-stage data-memory sequencer.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } dmem_st_e;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_BUSERR   = 2'd2;
  localparam logic [1:0] FLT_TIMEOUT  = 2'd3;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus: one valid/ready request channel plus a response strobe.
interface dmem_access_ctrl_if;

  logic        req_valid_o;
  logic        req_ready_i;
  logic        req_we_o;
  logic [31:0] req_addr_o;
  logic [31:0] req_wdata_o;
  logic [3:0]  req_be_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_rdata_i;
  logic        rsp_err_i;

  modport master (
    output req_valid_o, req_we_o, req_addr_o, req_wdata_o, req_be_o,
    input  req_ready_i, rsp_valid_i, rsp_rdata_i, rsp_err_i
  );

  modport slave (
    input  req_valid_o, req_we_o, req_addr_o, req_wdata_o, req_be_o,
    output req_ready_i, rsp_valid_i, rsp_rdata_i, rsp_err_i
  );

endinterface

// File: rtl/be_align_chk.sv
// Legality check of a pre-shifted byte-lane mask against the address offset.
module be_align_chk (
  input  logic [3:0] byte_en_i,
  input  logic       addr1_i,
  output logic       misalign_o
);

  // Single bytes and full words are always legal; halfwords must sit on the half named by addr[1].
  always_comb begin
    misalign_o = 1'b1;
    case (byte_en_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111: misalign_o = 1'b0;
      4'b0011: misalign_o = addr1_i;
      4'b1100: misalign_o = ~addr1_i;
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: turns one EX/MEM load/store into one bus request + response,
// stalling the pipeline until the access completes.
//
// state | meaning
// IDLE  | no access in flight; a new access is decoded here
// REQ   | req_valid_o asserted, waiting for req_ready_i
// RESP  | request accepted, waiting for rsp_valid_i
// DONE  | one-cycle completion, status reported, stall released
module dmem_access_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  input  logic [3:0]                byte_en_i,
  dmem_access_ctrl_if.master        bus,
  output logic                      stall_mem_o,
  output logic [31:0]               ld_data_o,
  output logic                      done_o,
  output logic                      fault_o,
  output logic [1:0]                fault_code_o
);

  localparam bit              TO_EN   = (TIMEOUT_CYC > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;

  dmem_st_e        state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]     ld_data_q, ld_data_d;
  logic [1:0]      flt_q, flt_d;
  logic            acc;
  logic            misalign;
  logic            to_hit;
  logic            unused_addr0;

  be_align_chk u_be_chk (
    .byte_en_i  (byte_en_i),
    .addr1_i    (addr_i[1]),
    .misalign_o (misalign)
  );

  assign acc          = mem_read_i | mem_write_i;
  assign unused_addr0 = addr_i[0];
  // Counter holds the number of REQ/RESP cycles already spent, so the last allowed cycle aborts.
  assign to_hit       = TO_EN && (to_cnt_q == TO_LAST);
  assign ld_data_o    = ld_data_q;

  // State, timeout counter, load data and captured fault status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      to_cnt_q  <= '0;
      ld_data_q <= '0;
      flt_q     <= FLT_NONE;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      ld_data_q <= ld_data_d;
      flt_q     <= flt_d;
    end
  end

  // Next-state and output decode; a simultaneous read+write is handled as a store.
  always_comb begin
    state_d          = state_q;
    to_cnt_d         = to_cnt_q;
    ld_data_d        = ld_data_q;
    flt_d            = flt_q;
    stall_mem_o      = 1'b0;
    done_o           = 1'b0;
    fault_o          = 1'b0;
    fault_code_o     = FLT_NONE;
    bus.req_valid_o  = 1'b0;
    bus.req_we_o     = 1'b0;
    bus.req_addr_o   = '0;
    bus.req_wdata_o  = '0;
    bus.req_be_o     = '0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          stall_mem_o = 1'b1;
          if (misalign) begin
            state_d = DONE;
            flt_d   = FLT_MISALIGN;
          end else begin
            state_d  = REQ;
            to_cnt_d = '0;
            flt_d    = FLT_NONE;
          end
        end
      end
      REQ: begin
        stall_mem_o     = 1'b1;
        bus.req_valid_o = 1'b1;
        bus.req_we_o    = mem_write_i;
        bus.req_addr_o  = {addr_i[31:2], 2'b00};
        bus.req_wdata_o = wdata_i;
        bus.req_be_o    = byte_en_i;
        to_cnt_d        = to_cnt_q + 1'b1;
        if (to_hit) begin
          state_d = DONE;
          flt_d   = FLT_TIMEOUT;
        end else if (bus.req_ready_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        stall_mem_o = 1'b1;
        to_cnt_d    = to_cnt_q + 1'b1;
        if (bus.rsp_valid_i) begin
          if (!mem_write_i) ld_data_d = bus.rsp_rdata_i;
          flt_d   = bus.rsp_err_i ? FLT_BUSERR : FLT_NONE;
          state_d = DONE;
        end else if (to_hit) begin
          flt_d   = FLT_TIMEOUT;
          state_d = DONE;
        end
      end
      DONE: begin
        done_o       = 1'b1;
        fault_o      = (flt_q != FLT_NONE);
        fault_code_o = flt_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a cycle-stepped bus responder.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        stall, done, fault;
  logic [31:0] ld_data;
  logic [1:0]  fault_code;

  int n_checks = 0;
  int n_errors = 0;

  int   r_stall, r_reqv, r_cyc, r_first_req;
  logic r_hold_ok, r_done_seen;

  dmem_access_ctrl_if bus_if ();

  dmem_access_ctrl #(.TIMEOUT_CYC(8), .TO_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .byte_en_i    (be),
    .bus          (bus_if.master),
    .stall_mem_o  (stall),
    .ld_data_o    (ld_data),
    .done_o       (done),
    .fault_o      (fault),
    .fault_code_o (fault_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    be        = b;
  endtask

  task automatic clr_acc();
    set_acc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Starts in the IDLE cycle of an access; returns in the DONE cycle (or after the bound).
  task automatic run_acc(input int rdy_dly, input int rsp_dly, input logic err,
                         input logic [31:0] rdata, input logic drop_rsp);
    int   wait_r, wait_s;
    logic accepted;
    wait_r = 0; wait_s = 0; accepted = 1'b0;
    r_stall = 0; r_reqv = 0; r_cyc = -1; r_first_req = -1;
    r_hold_ok = 1'b1; r_done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      bus_if.req_ready_i = 1'b0;
      bus_if.rsp_valid_i = 1'b0;
      bus_if.rsp_err_i   = 1'b0;
      bus_if.rsp_rdata_i = 32'hBAD0_BAD0;
      if (bus_if.req_valid_o) begin
        if (r_first_req < 0) r_first_req = c;
        r_reqv++;
        if (bus_if.req_addr_o !== {addr[31:2], 2'b00} || bus_if.req_wdata_o !== wdata ||
            bus_if.req_be_o !== be || bus_if.req_we_o !== mem_write)
          r_hold_ok = 1'b0;
        if (wait_r >= rdy_dly) begin
          bus_if.req_ready_i = 1'b1;
          accepted = 1'b1;
        end
        wait_r++;
      end else if (accepted && !drop_rsp) begin
        if (wait_s >= rsp_dly) begin
          bus_if.rsp_valid_i = 1'b1;
          bus_if.rsp_err_i   = err;
          bus_if.rsp_rdata_i = rdata;
        end
        wait_s++;
      end
      #1;
      if (stall) r_stall++;
      if (done) begin
        r_done_seen = 1'b1;
        r_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus_if.req_ready_i = 1'b0;
    bus_if.rsp_valid_i = 1'b0;
    bus_if.rsp_err_i   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_acc();
    bus_if.req_ready_i = 1'b0;
    bus_if.rsp_valid_i = 1'b0;
    bus_if.rsp_rdata_i = 32'h0;
    bus_if.rsp_err_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_fault_code", fault_code, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_req_valid", bus_if.req_valid_o, 0);
    rst_n = 1'b1;
    tick();

    // 1: word load, ready in first REQ cycle, response one cycle later
    set_acc(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    run_acc(0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    chk("t1_done_seen", r_done_seen, 1);
    chk("t1_stall_cycles", r_stall, 3);
    chk("t1_done_cycle", r_cyc, 3);
    chk("t1_req_cycles", r_reqv, 1);
    chk("t1_ld_data", ld_data, 32'hDEAD_BEEF);
    chk("t1_fault", fault, 0);
    chk("t1_fault_code", fault_code, 0);
    clr_acc();
    tick();
    chk("t1_done_one_cycle", done, 0);

    // 2: halfword store, ready delayed five cycles
    set_acc(1'b0, 1'b1, 32'h202, 32'hA5A5_1234, 4'b1100);
    run_acc(5, 0, 1'b0, 32'h1111_2222, 1'b0);
    chk("t2_done_seen", r_done_seen, 1);
    chk("t2_req_cycles", r_reqv, 6);
    chk("t2_req_stable", r_hold_ok, 1);
    chk("t2_stall_cycles", r_stall, 8);
    chk("t2_ld_kept", ld_data, 32'hDEAD_BEEF);
    chk("t2_fault_code", fault_code, 0);
    clr_acc();
    tick();

    // 3: halfword 0011 on the upper half -> misaligned, no bus request
    set_acc(1'b1, 1'b0, 32'h102, 32'h0, 4'b0011);
    run_acc(0, 0, 1'b0, 32'h0, 1'b0);
    chk("t3_done_seen", r_done_seen, 1);
    chk("t3_req_cycles", r_reqv, 0);
    chk("t3_done_cycle", r_cyc, 1);
    chk("t3_fault", fault, 1);
    chk("t3_fault_code", fault_code, 1);
    clr_acc();
    tick();

    // 3b: non-contiguous mask is illegal
    set_acc(1'b0, 1'b1, 32'h100, 32'h5555_AAAA, 4'b0101);
    run_acc(0, 0, 1'b0, 32'h0, 1'b0);
    chk("t3b_req_cycles", r_reqv, 0);
    chk("t3b_fault_code", fault_code, 1);
    clr_acc();
    tick();

    // 4: accepted load never answered -> timeout eight cycles after REQ entry
    set_acc(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
    run_acc(0, 0, 1'b0, 32'h0, 1'b1);
    chk("t4_done_seen", r_done_seen, 1);
    chk("t4_first_req", r_first_req, 1);
    chk("t4_req_to_done", r_cyc - r_first_req, 8);
    chk("t4_fault_code", fault_code, 3);
    chk("t4_fault", fault, 1);
    chk("t4_ld_kept", ld_data, 32'hDEAD_BEEF);
    clr_acc();
    tick();
    bus_if.rsp_valid_i = 1'b1;
    bus_if.rsp_rdata_i = 32'h1234_5678;
    #1;
    chk("t4_stray_stall", stall, 0);
    tick();
    bus_if.rsp_valid_i = 1'b0;
    #1;
    chk("t4_stray_done", done, 0);
    chk("t4_stray_ld", ld_data, 32'hDEAD_BEEF);

    // 5: reset while waiting in RESP
    set_acc(1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    tick();
    bus_if.req_ready_i = 1'b1;
    #1;
    chk("t5_in_req", bus_if.req_valid_o, 1);
    tick();
    bus_if.req_ready_i = 1'b0;
    #1;
    chk("t5_in_resp_stall", stall, 1);
    chk("t5_in_resp_valid", bus_if.req_valid_o, 0);
    rst_n = 1'b0;
    clr_acc();
    tick();
    chk("t5_rst_stall", stall, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_fault", fault, 0);
    chk("t5_rst_code", fault_code, 0);
    chk("t5_rst_ld", ld_data, 0);
    rst_n = 1'b1;
    tick();
    chk("t5_after_stall", stall, 0);

    // 6: back-to-back load then store with bus error
    set_acc(1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    run_acc(0, 0, 1'b0, 32'hCAFE_F00D, 1'b0);
    chk("t6_load_ld", ld_data, 32'hCAFE_F00D);
    chk("t6_load_code", fault_code, 0);
    set_acc(1'b0, 1'b1, 32'h304, 32'h1122_3344, 4'hF);
    tick();
    #1;
    chk("t6_no_gap_stall", stall, 1);
    chk("t6_no_gap_done", done, 0);
    run_acc(0, 0, 1'b1, 32'h9999_9999, 1'b0);
    chk("t6_done_seen", r_done_seen, 1);
    chk("t6_first_req", r_first_req, 1);
    chk("t6_stall_cycles", r_stall, 3);
    chk("t6_fault", fault, 1);
    chk("t6_fault_code", fault_code, 2);
    chk("t6_ld_kept", ld_data, 32'hCAFE_F00D);
    clr_acc();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
